// File: rtl/menu_ctrl_pkg.sv
// Shared types and constants for the start-menu controller and the menu renderer.
package menu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_ARMED = 3'd1,
        ST_START = 3'd2,
        ST_GAME  = 3'd3,
        ST_PAUSE = 3'd4
    } state_e;

    localparam logic [1:0] SEL_MENU  = 2'b00;
    localparam logic [1:0] SEL_GAME  = 2'b01;
    localparam logic [1:0] SEL_PAUSE = 2'b10;

    localparam int unsigned BTN_X0_DEF = 500;
    localparam int unsigned BTN_X1_DEF = 560;
    localparam int unsigned BTN_Y0_DEF = 320;
    localparam int unsigned BTN_Y1_DEF = 350;

    function automatic logic [1:0] sel_of(state_e s);
        logic [1:0] r;
        r = SEL_MENU;
        if (s == ST_GAME) r = SEL_GAME;
        if (s == ST_PAUSE) r = SEL_PAUSE;
        return r;
    endfunction

endpackage

// File: rtl/menu_ctrl_if.sv
// Signal bundle between the timing/input side and the menu controller.
interface menu_ctrl_if;

    logic        vblnk_in;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        esc_key;
    logic        game_over;
    logic [1:0]  screen_sel;
    logic        btn_hover;
    logic        game_start;
    logic [2:0]  state_dbg;

    modport master (
        output vblnk_in, mouse_xpos, mouse_ypos,
        output mouse_left, esc_key, game_over,
        input  screen_sel, btn_hover, game_start, state_dbg
    );

    modport slave (
        input  vblnk_in, mouse_xpos, mouse_ypos,
        input  mouse_left, esc_key, game_over,
        output screen_sel, btn_hover, game_start, state_dbg
    );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous level, with rise/fall pulses
// taken on the synchronised side.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= {sh_q[1:0], d_i};
    end

    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/menu_ctrl.sv
// Start-menu / game / pause screen controller; steps once per frame on the
// vblank tick using input events accumulated over the previous frame.
module menu_ctrl
    import menu_ctrl_pkg::*;
#(
    parameter int unsigned BTN_X0       = BTN_X0_DEF,
    parameter int unsigned BTN_X1       = BTN_X1_DEF,
    parameter int unsigned BTN_Y0       = BTN_Y0_DEF,
    parameter int unsigned BTN_Y1       = BTN_Y1_DEF,
    parameter int unsigned START_FRAMES = 4
) (
    input logic        clk,
    input logic        rst_n,
    menu_ctrl_if.slave bus
);

    localparam logic [11:0] X0 = 12'(BTN_X0);
    localparam logic [11:0] X1 = 12'(BTN_X1);
    localparam logic [11:0] Y0 = 12'(BTN_Y0);
    localparam logic [11:0] Y1 = 12'(BTN_Y1);
    localparam logic [3:0]  CNT_LOAD = 4'(START_FRAMES - 1);

    logic   clk_rise, clk_fall, esc_rise, esc_fall_unused;
    logic   vb_q, tick_q;
    logic   press_q, rel_q, esc_q, go_q;
    logic   hov_now, hov_q, hov_d;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic   gs_q, gs_d;

    edge_sync u_sync_click (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.mouse_left),
        .rise_o (clk_rise),
        .fall_o (clk_fall)
    );

    edge_sync u_sync_esc (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.esc_key),
        .rise_o (esc_rise),
        .fall_o (esc_fall_unused)
    );

    assign hov_now = (bus.mouse_xpos >= X0) && (bus.mouse_xpos <= X1) &&
                     (bus.mouse_ypos >= Y0) && (bus.mouse_ypos <= Y1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        hov_d   = hov_q;
        gs_d    = 1'b0;
        if (tick_q) begin
            hov_d = hov_now;
            case (state_q)
                ST_MENU: begin
                    if (press_q && hov_now) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (rel_q) begin
                        state_d = hov_now ? ST_START : ST_MENU;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_START: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_GAME;
                        gs_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_GAME: begin
                    if (go_q)       state_d = ST_MENU;
                    else if (esc_q) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (esc_q)                  state_d = ST_GAME;
                    else if (press_q && hov_now) state_d = ST_MENU;
                end
                default: state_d = ST_MENU;
            endcase
            sel_d = sel_of(state_d);
        end
    end

    // An event landing in the tick cycle seeds the next frame's flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vb_q    <= 1'b0;
            tick_q  <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            esc_q   <= 1'b0;
            go_q    <= 1'b0;
            hov_q   <= 1'b0;
            state_q <= ST_MENU;
            cnt_q   <= '0;
            sel_q   <= SEL_MENU;
            gs_q    <= 1'b0;
        end else begin
            vb_q    <= bus.vblnk_in;
            tick_q  <= bus.vblnk_in & ~vb_q;
            press_q <= clk_rise | (press_q & ~tick_q);
            rel_q   <= clk_fall | (rel_q & ~tick_q);
            esc_q   <= esc_rise | (esc_q & ~tick_q);
            go_q    <= bus.game_over | (go_q & ~tick_q);
            hov_q   <= hov_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gs_q    <= gs_d;
        end
    end

    assign bus.screen_sel = sel_q;
    assign bus.btn_hover  = hov_q;
    assign bus.game_start = gs_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Frame-level randomized bench for menu_ctrl against a behavioural model.
module tb_menu_ctrl;

    localparam int M_MENU = 0, M_ARMED = 1, M_START = 2;
    localparam int M_GAME = 3, M_PAUSE = 4;
    localparam int NFR = 4;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;
    int   gs_total = 0;

    int m_st, m_left, m_hov;
    bit m_carry;

    menu_ctrl_if bus ();

    menu_ctrl #(
        .BTN_X0(500), .BTN_X1(560), .BTN_Y0(320), .BTN_Y1(350),
        .START_FRAMES(NFR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.game_start === 1'b1) gs_total++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int in_btn(input int x, input int y);
        return (x >= 500 && x <= 560 && y >= 320 && y <= 350) ? 1 : 0;
    endfunction

    function automatic int sel_model(input int s);
        return (s == M_GAME) ? 1 : (s == M_PAUSE) ? 2 : 0;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // op: 0 none, 1 press, 2 release, 3 both edges
    task automatic frame(input string tag, input int x, input int y,
                         input int op, input bit esc, input bit go,
                         input bit esc_late);
        bit p, r, e, g;
        int gs0, hv, gs_exp;
        p = 0; r = 0; g = 0;
        e = m_carry;
        @(negedge clk);
        gs0 = gs_total;
        bus.mouse_xpos = 12'(x);
        bus.mouse_ypos = 12'(y);
        wait_n(2);
        if (op == 1 && !bus.mouse_left) begin
            bus.mouse_left = 1'b1; p = 1;
        end else if (op == 2 && bus.mouse_left) begin
            bus.mouse_left = 1'b0; r = 1;
        end else if (op == 3) begin
            bus.mouse_left = ~bus.mouse_left;
            wait_n(6);
            bus.mouse_left = ~bus.mouse_left;
            p = 1; r = 1;
        end
        wait_n(6);
        if (esc) begin
            bus.esc_key = 1'b1; wait_n(4);
            bus.esc_key = 1'b0; e = 1;
        end
        if (go) begin
            bus.game_over = 1'b1; wait_n(1);
            bus.game_over = 1'b0; g = 1;
        end
        wait_n(8);
        if (esc_late) begin
            bus.esc_key = 1'b1; wait_n(1);
        end
        bus.vblnk_in = 1'b1;
        wait_n(4);
        bus.vblnk_in = 1'b0;
        bus.esc_key  = 1'b0;
        wait_n(6);

        hv = in_btn(x, y);
        gs_exp = 0;
        m_carry = esc_late;
        m_hov = hv;
        case (m_st)
            M_MENU:  if (p && hv) m_st = M_ARMED;
            M_ARMED: if (r) begin
                m_st = hv ? M_START : M_MENU;
                m_left = NFR;
            end
            M_START: begin
                m_left--;
                if (m_left == 0) begin
                    m_st = M_GAME; gs_exp = 1;
                end
            end
            M_GAME:  if (g) m_st = M_MENU;
                     else if (e) m_st = M_PAUSE;
            default: if (e) m_st = M_GAME;
                     else if (p && hv) m_st = M_MENU;
        endcase

        check({tag, ".state"}, int'(bus.state_dbg), m_st);
        check({tag, ".sel"}, int'(bus.screen_sel), sel_model(m_st));
        check({tag, ".hover"}, int'(bus.btn_hover), m_hov);
        check({tag, ".gs"}, gs_total - gs0, gs_exp);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".state"}, int'(bus.state_dbg), 0);
        check({tag, ".sel"}, int'(bus.screen_sel), 0);
        check({tag, ".hover"}, int'(bus.btn_hover), 0);
        check({tag, ".gs"}, int'(bus.game_start), 0);
    endtask

    task automatic to_game(input string tag);
        frame({tag, ".press"}, 530, 335, 1, 0, 0, 0);
        frame({tag, ".rel"}, 530, 335, 2, 0, 0, 0);
        for (int i = 0; i < NFR; i++) frame({tag, ".cnt"}, 530, 335, 0, 0, 0, 0);
    endtask

    initial begin
        int x, y, op, gs0;
        rst_n = 1'b0;
        bus.vblnk_in = 1'b0;
        bus.mouse_xpos = '0;
        bus.mouse_ypos = '0;
        bus.mouse_left = 1'b0;
        bus.esc_key = 1'b0;
        bus.game_over = 1'b0;
        m_st = M_MENU; m_left = 0; m_hov = 0; m_carry = 0;
        wait_n(3);
        reset_checks("reset");
        rst_n = 1'b1;
        wait_n(4);

        to_game("start");
        frame("pause", 300, 300, 0, 1, 0, 0);
        frame("resume", 300, 300, 0, 1, 0, 0);
        frame("go_esc", 300, 300, 0, 1, 1, 0);
        frame("edge561", 561, 335, 3, 0, 0, 0);
        frame("edge560", 560, 350, 3, 0, 0, 0);
        frame("abort.press", 530, 335, 1, 0, 0, 0);
        frame("abort.rel", 100, 100, 2, 0, 0, 0);

        to_game("carry");
        frame("carry.tick", 10, 10, 0, 0, 0, 1);
        frame("carry.next", 10, 10, 0, 0, 0, 0);
        frame("carry.back", 10, 10, 0, 1, 0, 0);
        frame("carry.go", 10, 10, 0, 0, 1, 0);

        frame("rst.press", 530, 335, 1, 0, 0, 0);
        frame("rst.rel", 530, 335, 2, 0, 0, 0);
        frame("rst.cnt", 530, 335, 0, 0, 0, 0);
        gs0 = gs_total;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("rst.async");
        wait_n(3);
        rst_n = 1'b1;
        m_st = M_MENU; m_hov = 0; m_carry = 0;
        for (int i = 0; i < 6; i++) frame("rst.after", 530, 335, 0, 0, 0, 0);
        check("rst.nogs", gs_total - gs0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                x = 498 + int'($urandom_range(0, 64));
                y = 318 + int'($urandom_range(0, 34));
            end else begin
                x = int'($urandom_range(0, 4095));
                y = int'($urandom_range(0, 4095));
            end
            op = int'($urandom_range(0, 3));
            frame("rand", x, y, op,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
